matmul_datapath: RTL
====================

// Module: matmul_datapath
// PURPOSE
// - Datapath responder to the matmul control FSM: obeys load_matrix/multiply_matrix/add/done, returns entry_count.
// - Holds two N-entry operand vectors (row of A, column of B); computes one dot product per FSM pass.
// - Host side loads operands through a write port and collects result via a one-cycle result_valid pulse.
// PARAMETERS
// - DATA_W  8   operand width, unsigned
// - N       8   vector length; FSM leaves Multiply when entry_count == N-1
// - CNT_W   4   entry_count width; must satisfy 2**CNT_W > N-1
// - ACC_W   DATA_W*2+3   result width (2*DATA_W + clog2(N)); no overflow possible
// PORTS
// - clock            in   1       rising-edge clock
// - reset            in   1       synchronous, active-high
// - load_matrix      in   1       from FSM; high with multiply_matrix in Multiply state
// - multiply_matrix  in   1       from FSM; step qualifier
// - add              in   1       from FSM; one-cycle Accumulate
// - done             in   1       from FSM; one-cycle Store
// - wr_en            in   1       host operand write strobe
// - wr_sel           in   1       0 = vector A, 1 = vector B
// - wr_addr          in   CNT_W   operand index, 0..N-1
// - wr_data          in   DATA_W  operand value
// - entry_count      out  CNT_W   to FSM; index of current multiply step
// - busy             out  1       high from first multiply step through done cycle
// - result           out  ACC_W   last completed dot product
// - result_valid     out  1       one-cycle pulse, result updated
// - protocol_err     out  1       sticky protocol violation flag
// BEHAVIOUR
// - Reset: entry_count=0, busy=0, result=0, result_valid=0, protocol_err=0; A, B, product regs, acc all cleared.
// - Reset mid-operation aborts immediately; no result_valid is produced for the aborted pass.
// - step = load_matrix & multiply_matrix; one product per step cycle.
// - On step: prod[entry_count] <= A[entry_count]*B[entry_count] (2*DATA_W bits, unsigned); busy <= 1.
// - entry_count increments on step while < N-1; holds at N-1 (no wrap), giving exactly N steps per pass.
// - Step while entry_count==N-1 and prod[N-1] already written this pass: overwrite prod[N-1], set protocol_err.
// - Only one of load_matrix/multiply_matrix high: no step, protocol_err set.
// - add: acc <= sum of prod[0..N-1] zero-extended to ACC_W; registered, 1-cycle latency.
// - add with entry_count != N-1: acc still computed, protocol_err set.
// - done: result <= acc; result_valid=1 next cycle only; entry_count <= 0; busy <= 0; prod regs retained.
// - done in same cycle as add: protocol_err set; result takes old acc.
// - Latency: first step to result_valid = N + 2 cycles (N steps, add, done) + 1 register stage.
// - Host write: when wr_en & !busy & wr_addr<N, A/B[wr_addr] <= wr_data at clock edge.
// - wr_en while busy, or wr_addr>=N: write dropped, protocol_err set; operands stable during a pass.
// - wr_en in the same cycle busy falls (done cycle): dropped (busy still 1 that cycle).
// - protocol_err clears only on reset.
// - Operands persist across passes; rerunning FSM with no writes reproduces the same result.
// STRUCTURE
// - Shared package matmul_pkg: DATA_W, N, CNT_W, ACC_W defaults; FSM state encodings (Idle/Multiply/Accumulate/Store)
//   so FSM and datapath agree on N-1 terminal count.
// - One sub-module: matmul_operand_rf (2 x N x DATA_W register file, one write port, one indexed read port per vector).
// - Multiplier, product regs, adder tree, counter, result reg inline in matmul_datapath.
// TESTING
// - A=1..8, B=all 1, FSM pass -> entry_count 0..7 over 8 steps, result=36, result_valid one cycle, err=0.
// - A=B=all 255 -> result=520200 (no overflow in 19 bits); second pass without writes -> 520200 again.
// - wr_en during Multiply (addr 3, data 9) -> write dropped, A[3] unchanged, protocol_err=1.
// - Reset asserted at entry_count=4 -> next cycle entry_count=0, busy=0, no result_valid; rerun gives correct result.
// - Extra step at entry_count=7 (3 data, 9 steps) -> entry_count holds 7, protocol_err=1, no wrap to 0.
// - Back-to-back passes: A=1..8,B=1 then B=2 between passes -> result 36 then 72, two separate result_valid pulses.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul control FSM and its datapath.
// Holds the operand/result widths, the vector length and its terminal
// count, and the control FSM state encodings, so both sides agree on when
// a multiply pass is complete.
package matmul_pkg;

  localparam int DATA_W = 8;
  localparam int N      = 8;
  localparam int CNT_W  = 4;
  localparam int PROD_W = 2 * DATA_W;
  // 2*DATA_W + clog2(N): the sum of N full-scale products cannot overflow.
  localparam int ACC_W  = 2 * DATA_W + 3;
  localparam int IDX_W  = $clog2(N);

  // Terminal count: the FSM leaves Multiply when entry_count reaches this.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_MULTIPLY   = 2'd1,
    ST_ACCUMULATE = 2'd2,
    ST_STORE      = 2'd3
  } fsm_state_e;

endpackage

// File: rtl/matmul_if.sv
// Bundle of the matmul datapath's control, host-write and status signals.
//   master : FSM/host side (drives commands and operand writes)
//   slave  : datapath side (returns entry_count, busy, result, flags)
interface matmul_if;
  import matmul_pkg::*;

  logic                load_matrix;
  logic                multiply_matrix;
  logic                add;
  logic                done;
  logic                wr_en;
  logic                wr_sel;
  logic [CNT_W-1:0]    wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [CNT_W-1:0]    entry_count;
  logic                busy;
  logic [ACC_W-1:0]    result;
  logic                result_valid;
  logic                protocol_err;

  modport master (
    output load_matrix, multiply_matrix, add, done,
    output wr_en, wr_sel, wr_addr, wr_data,
    input  entry_count, busy, result, result_valid, protocol_err
  );

  modport slave (
    input  load_matrix, multiply_matrix, add, done,
    input  wr_en, wr_sel, wr_addr, wr_data,
    output entry_count, busy, result, result_valid, protocol_err
  );

endinterface

// File: rtl/matmul_operand_rf.sv
// Operand storage: two N-entry vectors (A = row, B = column) of DATA_W bits.
// One write port selecting the vector, one shared read index returning the
// matching entry of both vectors combinationally.
//   clock, reset     : clock, synchronous active-high reset (clears all)
//   i_wr_en          : already-qualified write strobe
//   i_wr_sel         : 0 = A, 1 = B
//   i_wr_idx/i_wr_data : write index and value
//   i_rd_idx         : read index
//   o_rd_a/o_rd_b    : A[i_rd_idx], B[i_rd_idx]
module matmul_operand_rf
  import matmul_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic              i_wr_sel,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [DATA_W-1:0] o_rd_a,
  output logic [DATA_W-1:0] o_rd_b
);

  logic [DATA_W-1:0] r_vec_a [N];
  logic [DATA_W-1:0] r_vec_b [N];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_vec_a[i] <= '0;
        r_vec_b[i] <= '0;
      end
    end else if (i_wr_en) begin
      if (i_wr_sel) r_vec_b[i_wr_idx] <= i_wr_data;
      else          r_vec_a[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_a = r_vec_a[i_rd_idx];
  assign o_rd_b = r_vec_b[i_rd_idx];

endmodule

// File: rtl/matmul_datapath.sv
// Datapath responder to the matmul control FSM. Each step (load_matrix and
// multiply_matrix both high) multiplies A[entry_count]*B[entry_count] into a
// product register; add sums all N products into the accumulator; done moves
// the accumulator to result and pulses result_valid the following cycle.
//   clock, reset : clock, synchronous active-high reset
//   bus (slave)  : commands, host operand writes, entry_count/busy/result
//                  status and the sticky protocol_err flag
module matmul_datapath
  import matmul_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  matmul_if.slave bus
);

  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_last_written;
  logic [PROD_W-1:0] r_prod [N];
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_result;
  logic              r_result_valid;
  logic              r_protocol_err;

  logic              w_step;
  logic              w_half_step;
  logic              w_at_last;
  logic              w_addr_ok;
  logic              w_wr_ok;
  logic              w_wr_bad;
  logic              w_err_now;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic [PROD_W-1:0] w_prod;
  logic [ACC_W-1:0]  w_sum;

  assign w_step      = bus.load_matrix & bus.multiply_matrix;
  assign w_half_step = bus.load_matrix ^ bus.multiply_matrix;
  assign w_at_last   = (r_cnt == LAST_IDX);

  // Writes are refused for the whole pass, including the done cycle, since
  // busy is registered and only falls after that edge.
  assign w_addr_ok = (bus.wr_addr < CNT_W'(N));
  assign w_wr_ok   = bus.wr_en & ~r_busy & w_addr_ok;
  assign w_wr_bad  = bus.wr_en & ~w_wr_ok;

  // r_last_written marks that the final slot was already filled this pass,
  // so a further step at the terminal count is an overrun.
  assign w_err_now = w_half_step
                   | (w_step & w_at_last & r_last_written)
                   | (bus.add & ~w_at_last)
                   | (bus.add & bus.done)
                   | w_wr_bad;

  // r_cnt never exceeds N-1, so its low bits are a valid vector index.
  assign w_rd_idx = r_cnt[IDX_W-1:0];

  matmul_operand_rf u_operand_rf (
    .clock     (clock),
    .reset     (reset),
    .i_wr_en   (w_wr_ok),
    .i_wr_sel  (bus.wr_sel),
    .i_wr_idx  (bus.wr_addr[IDX_W-1:0]),
    .i_wr_data (bus.wr_data),
    .i_rd_idx  (w_rd_idx),
    .o_rd_a    (w_rd_a),
    .o_rd_b    (w_rd_b)
  );

  assign w_prod = PROD_W'(w_rd_a) * PROD_W'(w_rd_b);

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = w_sum + ACC_W'(r_prod[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt          <= '0;
      r_busy         <= 1'b0;
      r_last_written <= 1'b0;
      r_acc          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_protocol_err <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_prod[i] <= '0;
      end
    end else begin
      r_result_valid <= bus.done;
      if (w_err_now) r_protocol_err <= 1'b1;

      if (w_step) begin
        r_prod[w_rd_idx] <= w_prod;
        r_busy           <= 1'b1;
        if (w_at_last) r_last_written <= 1'b1;
        else           r_cnt          <= r_cnt + CNT_W'(1);
      end

      if (bus.add) r_acc <= w_sum;

      // done takes priority over a coincident step: the pass is closed.
      if (bus.done) begin
        r_result       <= r_acc;
        r_cnt          <= '0;
        r_busy         <= 1'b0;
        r_last_written <= 1'b0;
      end
    end
  end

  assign bus.entry_count  = r_cnt;
  assign bus.busy         = r_busy;
  assign bus.result       = r_result;
  assign bus.result_valid = r_result_valid;
  assign bus.protocol_err = r_protocol_err;

endmodule
